// File: rtl/vit_pkg.sv
// Shared types and defaults for the Viterbi frame sequencer.
package vit_pkg;

    localparam int unsigned VIT_FRAME_LEN = 256;

    typedef logic [1:0] vit_pair_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACS   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_TB    = 3'd3,
        ST_DONE  = 3'd4
    } vit_ctrl_state_t;

endpackage

// File: rtl/vit_idx_cnt.sv
// Loadable up/down index counter with a terminal-count flag.
module vit_idx_cnt #(
    parameter int unsigned      WIDTH = 8,
    parameter bit               UP    = 1'b1,
    parameter logic [WIDTH-1:0] TERM  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             tc_c
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Load has priority over counting; the caller stops counting at TERM.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = UP ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign tc_c = (cnt_q == TERM);

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Viterbi frame sequencer: symbol intake to BMC/ACS, then traceback sweep.
// Optional statistics counters (frame_cnt, abort_cnt) under VIT_CTRL_STATS_EN.
module viterbi_frame_ctrl
    import vit_pkg::*;
#(
    parameter  int unsigned FRAME_LEN = VIT_FRAME_LEN,
    localparam int unsigned ADDR_W    = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  vit_pair_t         in_pair,
    input  logic              abort,
    output vit_pair_t         bmc_pair,
    output logic              acs_en,
    output logic              acs_first,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              tb_en,
    output logic [ADDR_W-1:0] tb_addr,
    output logic              frame_done
`ifdef VIT_CTRL_STATS_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       abort_cnt
`endif
);

    vit_ctrl_state_t   state_q, state_d;
    vit_pair_t         bmc_pair_q, bmc_pair_d;
    logic              acs_en_q, acs_en_d;
    logic              acs_first_q, acs_first_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              tb_en_q, tb_en_d;
    logic              frame_done_q, frame_done_d;

    logic              accept_c;
    logic              abort_hit_c;
    logic              accept_ok_c;
    logic [ADDR_W-1:0] sym_cnt;
    logic              sym_tc_c;
    logic [ADDR_W-1:0] tb_cnt;
    logic              tb_tc_c;

    assign in_ready    = ~rst & ((state_q == ST_IDLE) | (state_q == ST_ACS));
    assign accept_c    = in_valid & in_ready;
    assign abort_hit_c = abort & (state_q != ST_IDLE);
    assign accept_ok_c = accept_c & ~abort_hit_c;

    // sym_cnt holds the index the next ACS-state accept will write.
    vit_idx_cnt #(
        .WIDTH (ADDR_W),
        .UP    (1'b1),
        .TERM  (ADDR_W'(FRAME_LEN - 1))
    ) u_sym_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_ok_c & (state_q == ST_IDLE)),
        .load_val (ADDR_W'(1)),
        .en       (accept_ok_c & (state_q == ST_ACS) & ~sym_tc_c),
        .cnt      (sym_cnt),
        .tc_c     (sym_tc_c)
    );

    // Traceback address sweeps FRAME_LEN-1 down to 0.
    vit_idx_cnt #(
        .WIDTH (ADDR_W),
        .UP    (1'b0),
        .TERM  ('0)
    ) u_tb_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     ((state_q == ST_FLUSH) & ~abort_hit_c),
        .load_val (ADDR_W'(FRAME_LEN - 1)),
        .en       ((state_q == ST_TB) & ~tb_tc_c & ~abort_hit_c),
        .cnt      (tb_cnt),
        .tc_c     (tb_tc_c)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_d      = state_q;
        bmc_pair_d   = bmc_pair_q;
        wr_addr_d    = wr_addr_q;
        acs_en_d     = 1'b0;
        acs_first_d  = 1'b0;

        unique case (state_q)
            ST_IDLE:  if (accept_c) state_d = ST_ACS;
            ST_ACS:   if (accept_c && sym_tc_c) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_TB;
            ST_TB:    if (tb_tc_c) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (abort_hit_c) begin
            state_d = ST_IDLE;
        end

        if (accept_ok_c) begin
            bmc_pair_d  = in_pair;
            acs_en_d    = 1'b1;
            acs_first_d = (state_q == ST_IDLE);
            wr_addr_d   = (state_q == ST_IDLE) ? '0 : sym_cnt;
        end

        tb_en_d      = (state_d == ST_TB);
        frame_done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bmc_pair_q   <= '0;
            acs_en_q     <= 1'b0;
            acs_first_q  <= 1'b0;
            wr_addr_q    <= '0;
            tb_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bmc_pair_q   <= bmc_pair_d;
            acs_en_q     <= acs_en_d;
            acs_first_q  <= acs_first_d;
            wr_addr_q    <= wr_addr_d;
            tb_en_q      <= tb_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bmc_pair   = bmc_pair_q;
    assign acs_en     = acs_en_q;
    assign acs_first  = acs_first_q;
    assign wr_addr    = wr_addr_q;
    assign tb_en      = tb_en_q;
    assign tb_addr    = tb_cnt;
    assign frame_done = frame_done_q;

`ifdef VIT_CTRL_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] abort_cnt_q, abort_cnt_d;

    // Frame count wraps; abort count saturates.
    always_comb begin
        frame_cnt_d = frame_cnt_q + 16'(frame_done_q);
        abort_cnt_d = abort_cnt_q;
        if (abort_hit_c && (abort_cnt_q != 16'hFFFF)) begin
            abort_cnt_d = abort_cnt_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            abort_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign abort_cnt = abort_cnt_q;
`endif

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Scoreboard bench for viterbi_frame_ctrl (FRAME_LEN = 8).
module tb_viterbi_frame_ctrl;

    localparam int unsigned F  = 8;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_pair;
    logic          abort;
    logic [1:0]    bmc_pair;
    logic          acs_en;
    logic          acs_first;
    logic [AW-1:0] wr_addr;
    logic          tb_en;
    logic [AW-1:0] tb_addr;
    logic          frame_done;
`ifdef VIT_CTRL_STATS_EN
    logic [15:0]   frame_cnt;
    logic [15:0]   abort_cnt;
`endif

    viterbi_frame_ctrl #(.FRAME_LEN(F)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pair    (in_pair),
        .abort      (abort),
        .bmc_pair   (bmc_pair),
        .acs_en     (acs_en),
        .acs_first  (acs_first),
        .wr_addr    (wr_addr),
        .tb_en      (tb_en),
        .tb_addr    (tb_addr),
        .frame_done (frame_done)
`ifdef VIT_CTRL_STATS_EN
        ,
        .frame_cnt  (frame_cnt),
        .abort_cnt  (abort_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       cyc;
        logic [1:0] pair;
        int       idx;
        bit       first;
    } sym_exp_t;

    typedef struct {
        int cyc;
        int addr;
    } tb_exp_t;

    sym_exp_t sym_q[$];
    tb_exp_t  tb_q[$];
    int       done_q[$];
    int       zero_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: frame progress in terms of accepted symbols and cycle stamps.
    int n_acc      = 0;
    int ready_from = 0;
    bit exp_ready  = 1'b0;
    int exp_frames = 0;
    int exp_aborts = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp_v);
        end
    endtask

    task automatic prune(input int c);
        while (tb_q.size() > 0 && tb_q[$].cyc > c) void'(tb_q.pop_back());
        while (done_q.size() > 0 && done_q[$] > c) begin
            void'(done_q.pop_back());
            exp_frames--;
        end
    endtask

    // Drive one cycle of inputs and push the expected consequences.
    task automatic step(input logic r, input logic v, input logic [1:0] p, input logic ab);
        int c;
        bit idle;
        bit rdy;
        c        = cyc;
        rst      = r;
        in_valid = v;
        in_pair  = p;
        abort    = ab;
        idle      = (n_acc == 0) && (c >= ready_from);
        rdy       = !r && (c >= ready_from);
        exp_ready = rdy;
        if (r) begin
            n_acc      = 0;
            ready_from = c + 1;
            prune(c);
            exp_frames = 0;
            exp_aborts = 0;
            zero_q.push_back(c + 1);
        end else if (ab && !idle) begin
            n_acc      = 0;
            ready_from = c + 1;
            prune(c);
            exp_aborts++;
        end else if (v && rdy) begin
            sym_q.push_back('{c + 1, p, n_acc, (n_acc == 0)});
            n_acc++;
            if (n_acc == F) begin
                n_acc      = 0;
                ready_from = c + 3 + F;
                for (int i = 0; i < F; i++) tb_q.push_back('{c + 2 + i, F - 1 - i});
                done_q.push_back(c + 2 + F);
                exp_frames++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'(i), 1'b0);
    endtask

    // Monitor: compare DUT outputs against the expectation queues each cycle.
    always @(negedge clk) begin : mon
        int  k;
        bit  ea;
        bit  et;
        bit  ed;
        k = cyc;
        chk("in_ready", 32'(in_ready), 32'(exp_ready));

        ea = (sym_q.size() > 0) && (sym_q[0].cyc == k);
        chk("acs_en", 32'(acs_en), 32'(ea));
        if (ea) begin
            if (acs_en) begin
                chk("bmc_pair", 32'(bmc_pair), 32'(sym_q[0].pair));
                chk("wr_addr", 32'(wr_addr), 32'(sym_q[0].idx));
                chk("acs_first", 32'(acs_first), 32'(sym_q[0].first));
            end
            void'(sym_q.pop_front());
        end else begin
            chk("acs_first_idle", 32'(acs_first), 32'd0);
        end

        et = (tb_q.size() > 0) && (tb_q[0].cyc == k);
        chk("tb_en", 32'(tb_en), 32'(et));
        if (et) begin
            if (tb_en) chk("tb_addr", 32'(tb_addr), 32'(tb_q[0].addr));
            void'(tb_q.pop_front());
        end

        ed = (done_q.size() > 0) && (done_q[0] == k);
        chk("frame_done", 32'(frame_done), 32'(ed));
        if (ed) void'(done_q.pop_front());

        if (zero_q.size() > 0 && zero_q[0] == k) begin
            chk("rst_bmc_pair", 32'(bmc_pair), 32'd0);
            chk("rst_wr_addr", 32'(wr_addr), 32'd0);
            chk("rst_tb_addr", 32'(tb_addr), 32'd0);
            void'(zero_q.pop_front());
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_pair  = 2'd0;
        abort    = 1'b0;
        @(posedge clk);
        #1;

        // Reset
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd0, 1'b0);

        // Gapless stream: pairs 0,1,2,3,... across two back-to-back frames
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 2'(i % 4), 1'b0);
        drain(14);

        // in_valid toggling every other cycle
        for (int i = 0; i < 16; i++) step(1'b0, (i % 2) == 0, 2'($urandom_range(0, 3)), 1'b0);
        drain(14);

        // Abort during traceback at tb_addr = 4
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b0);
        drain(4);
        step(1'b0, 1'b0, 2'd0, 1'b1);
        drain(4);

        // Abort coincident with an accept in ACS, then a fresh frame
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'(i), 1'b0);
        step(1'b0, 1'b1, 2'd3, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b0);
        drain(14);

        // Reset held 3 cycles mid-ACS, then a full frame
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'(i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'($urandom_range(0, 3)), 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b0);
        drain(14);

        // Randomized traffic with occasional abort and reset
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 75,
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 99) < 2);
        end
        drain(16);

        chk("sym_q_empty", 32'(sym_q.size()), 32'd0);
        chk("tb_q_empty", 32'(tb_q.size()), 32'd0);
        chk("done_q_empty", 32'(done_q.size()), 32'd0);
`ifdef VIT_CTRL_STATS_EN
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        chk("abort_cnt", 32'(abort_cnt), 32'(exp_aborts));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
